// File: rtl/dff_pipe_pkg.sv
// Shared defaults and helpers for the dff_pipe retiming pipeline.
package dff_pipe_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    // Counter width able to represent 0..depth occupied stages
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/dff_pipe_stage.sv
// One valid/data register stage; a bubble (empty stage) always accepts, collapsing gaps.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    assign rdy = !valid | dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (rdy) begin
            valid <= up_valid;
            // data is held across bubbles so out_data stays quiet when idle
            if (up_valid) data <= up_data;
        end
    end
endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage valid/ready register pipeline with flush.
// Define DFF_PIPE_OCC_EN to add the registered occupancy output.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0]   occupancy
`endif
);
    logic [DEPTH:0]                rdy;
    logic [DEPTH-1:0]              vld;
    logic [DEPTH-1:0][WIDTH-1:0]   dat;
    logic                          push;

    assign rdy[DEPTH] = out_ready;
    assign in_ready   = rdy[0] & !flush;
    assign push       = in_valid & in_ready;
    // Mask during flush so no downstream handshake completes on a word being discarded
    assign out_valid  = vld[DEPTH-1] & !flush;
    assign out_data   = dat[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        if (i == 0) begin : g_head
            assign up_v = push;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = vld[i-1];
            assign up_d = dat[i-1];
        end

        dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (rdy[i+1]),
            .rdy      (rdy[i]),
            .valid    (vld[i]),
            .data     (dat[i])
        );
    end

`ifdef DFF_PIPE_OCC_EN
    logic pop;
    assign pop = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              occupancy <= '0;
        else if (flush)          occupancy <= '0;
        else if (push && !pop)   occupancy <= occupancy + 1'b1;
        else if (pop && !push)   occupancy <= occupancy - 1'b1;
    end
`endif
endmodule
